// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame transmitter.
// SERIAL_FRAME_TX_PARITY_EN adds the PARITY state to the state encoding.
package serial_pkg;

    localparam int unsigned SEL_W   = 3;
    localparam int unsigned DATA_W  = 8;
    localparam logic        TX_IDLE = 1'b1;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

endpackage

// File: rtl/serial_frame_tx_mux8x1.sv
// Gate-level 8:1 multiplexer: Y = D[S], built as an AND-OR tree of decoded terms.
module mux8x1
    import serial_pkg::*;
(
    input  logic [DATA_W-1:0] D,
    input  logic [SEL_W-1:0]  S,
    output logic              Y
);

    logic [DATA_W-1:0] term;

    // One product term per data input, enabled when S matches its index.
    for (genvar i = 0; i < DATA_W; i++) begin : g_term
        localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
        assign term[i] = D[i] & ~(|(S ^ IDX));
    end

    assign Y = |term;

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, 8 data bits through mux8x1,
// optional even parity bit, then STOP_BITS stop bits, one bit per tick_en period.
// Build option: define SERIAL_FRAME_TX_PARITY_EN to insert the parity bit.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int unsigned MSB_FIRST = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              tick_en,
    output logic [SEL_W-1:0]  sel,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam logic [SEL_W-1:0] SEL_FIRST = (MSB_FIRST != 0) ? '1 : '0;
    localparam logic [SEL_W-1:0] SEL_LAST  = (MSB_FIRST != 0) ? '0 : '1;
    // Adding all-ones steps the select down by one (modular arithmetic).
    localparam logic [SEL_W-1:0] SEL_STEP  = (MSB_FIRST != 0) ? '1 : SEL_W'(1);
    localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

    state_t            state;
    state_t            state_d;
    logic [DATA_W-1:0] hold;
    logic [1:0]        stop_cnt;
    logic              done_q;
    logic              mux_y;

    mux8x1 u_mux (
        .D (hold),
        .S (sel),
        .Y (mux_y)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; tick_en only advances the frame once it is past IDLE.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (din_valid) state_d = START;
            START: if (tick_en) state_d = DATA;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            DATA:   if (tick_en && (sel == SEL_LAST)) state_d = PARITY;
            PARITY: if (tick_en) state_d = STOP;
`else
            DATA:   if (tick_en && (sel == SEL_LAST)) state_d = STOP;
`endif
            STOP:  if (tick_en && (stop_cnt == STOP_LAST)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: word hold, bit select, stop-bit counter, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold     <= '0;
            sel      <= SEL_FIRST;
            stop_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == STOP) && (state_d == IDLE);

            if ((state == IDLE) && din_valid) begin
                hold <= din;
            end

            if ((state == DATA) && tick_en && (sel != SEL_LAST)) begin
                sel <= sel + SEL_STEP;
            end else if ((state_d == IDLE) || ((state == START) && tick_en)) begin
                sel <= SEL_FIRST;
            end

            if (state == STOP) begin
                if (tick_en) begin
                    stop_cnt <= stop_cnt + 2'd1;
                end
            end else begin
                stop_cnt <= '0;
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        din_ready = (state == IDLE);
        busy      = (state != IDLE);
        tx        = TX_IDLE;
        unique case (state)
            START:  tx = 1'b0;
            DATA:   tx = mux_y;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: tx = ^hold;
`endif
            default: tx = TX_IDLE;
        endcase
    end

    assign done = done_q;

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial frame transmitter that sits directly upstream of the 8:1 multiplexer stage.
- Accepts one 8-bit word over a valid/ready handshake and holds it in a register that feeds the mux data inputs.
- Steps the mux 3-bit select through the eight bit positions at a bit-rate enable.
- Wraps the selected bit in a start/stop frame on tx.

Parameters:
- MSB_FIRST, 0, 0 = bit 0 sent first (sel counts 0→7); 1 = bit 7 first (sel counts 7→0).
- STOP_BITS, 1, number of stop bit periods, legal values 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  8  parallel word to transmit.
- din_valid  input  1  din is valid.
- din_ready  output  1  block can accept a word; high only in IDLE.
- tick_en  input  1  one-cycle bit-rate strobe; each bit period ends on a tick_en.
- sel  output  3  select lines driven to the mux sub-module; registered.
- tx  output  1  serial line; idle level 1.
- busy  output  1  high from the cycle after acceptance until return to IDLE.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, hold=8'h00, sel=0 (7 if MSB_FIRST), stop count=0.
  - tx=1, busy=0, done=0, din_ready=1.
  - Mid-frame reset aborts the frame immediately; tx returns to 1 with no partial stop bit.
- States and transitions:
  - IDLE → START: on din_valid && din_ready. din is latched into hold on that edge.
  - START: tx=0. On tick_en → DATA, with sel loaded to its first index.
  - DATA: tx = hold[sel], taken through the mux sub-module. On tick_en: if sel is the last index (7, or 0 if MSB_FIRST) → STOP (or PARITY when the option is enabled); otherwise sel steps by ±1.
  - STOP: tx=1. Each tick_en increments the stop count. On the STOP_BITS-th tick_en → IDLE, with done=1 for exactly the following cycle.
- tx is combinational from registered state, sel and hold only; there is no combinational path from din, din_valid or tick_en to tx.
- Frame length = 1 + 8 (+1 parity) + STOP_BITS tick_en periods.
- A tick_en in the acceptance cycle does not count: START lasts until the first tick_en strictly after acceptance.
- tick_en in IDLE is ignored. din_valid while busy is ignored (din_ready=0); the word is not lost, because the sender must hold it.
- Back-to-back frames: din_ready=1 in the same cycle done=1, so the next word can be accepted there with zero idle gap.
- hold is stable for the whole frame. sel only changes on a tick_en in DATA or on entry to DATA; it returns to its first index on entry to IDLE.
- busy = (state != IDLE).

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that lasts one tick_en period.
  - tx = ^hold (even parity: the total count of ones over data+parity is even).
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - The state encoding omits PARITY.

Decomposition:
- Shared package serial_pkg:
  - state typedef (IDLE, START, DATA, PARITY, STOP).
  - constants SEL_W=3, DATA_W=8, TX_IDLE=1'b1.
- Sub-module: the existing gate-level mux8x1 is instantiated with D=hold, S=sel; its Y output is the data-bit source for tx.
- Counter and FSM stay in serial_frame_tx.

Test Plan:
- Byte 8'hA5, MSB_FIRST=0, tick_en every 4 clocks → tx sequence 0,1,0,1,0,0,1,0,1,1. Each bit lasts 4 clocks; done pulses once; sel runs 0..7.
- MSB_FIRST=1, byte 8'h81 → tx sequence 0,1,0,0,0,0,0,0,1,1; sel runs 7→0.
- din_valid held high with 8'h3C then 8'hC3 → second word accepted in the done cycle; no idle tx cycles between the two frames.
- rst_n pulled low in the DATA bit-4 period → tx=1, busy=0, sel=0 asynchronously. After release, the next byte 8'hFF transmits a full frame.
- STOP_BITS=2 with SERIAL_FRAME_TX_PARITY_EN, byte 8'h07 → frame 0,1,1,1,0,0,0,0,0,1(parity),1,1. Total 12 tick periods.
- tick_en coincident with acceptance, plus din_valid pulses while busy → the START period is still a full tick period, and no extra words are accepted (din_ready=0).
